cache_rw_ri: RTL and testbench

CACHE_RW_RI -- requirements
Module: cache_rw_ri

---
 rtl/cache_rw_ri.sv | 208 ++++++++++++++++++++
 tb/tb_cache_rw_ri.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_rw_ri.sv
// Refill / IO engine behind cache_rw: uncached IO accesses and
// line refills with victim selection, partial-line merge and tag update.
module cache_rw_ri #(
   parameter int unsigned LINE_WORDS      = 16,
   parameter int unsigned DATA_ADDR_WIDTH = 9,
   parameter logic [3:0]  CMD_IORW        = 4'd1,
   parameter logic [3:0]  CMD_RB          = 4'd2
) (
   input  logic                       clk,
   input  logic                       rest,
   input  logic [3:0]                 cmd,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [31:0]                req_address,
   input  logic [3:0]                 req_byteEnable,
   input  logic                       req_read,
   input  logic                       req_write,
   input  logic [31:0]                req_writeData,
   input  logic                       isHaveFreeBlock,
   input  logic [1:0]                 freeBlockNum,
   input  logic [15:0]                dre_rDataAll,
   output logic [31:0]                m1_address,
   output logic [3:0]                 m1_byteEnable,
   output logic                       m1_read,
   output logic                       m1_write,
   output logic [31:0]                m1_writeData,
   input  logic                       m1_waitRequest,
   input  logic [31:0]                m1_readData,
   input  logic                       m1_readDataValid,
   output logic [DATA_ADDR_WIDTH-1:0] data_wAddr,
   output logic [1:0]                 data_wWay,
   output logic [31:0]                data_wData,
   output logic                       data_wEn,
   output logic [3:0]                 data_wByteEn,
   output logic [31:0]                tag_wData,
   output logic                       tag_wEn,
   output logic [15:0]                dre_wData,
   output logic                       dre_wEn,
   output logic [31:0]                io_readData,
   output logic                       io_readDataValid
);

   localparam int unsigned OFF = $clog2(LINE_WORDS);
   localparam int unsigned CW  = OFF + 1;
   localparam logic [CW-1:0] LW   = CW'(LINE_WORDS);
   localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE, IO_REQ, IO_WAIT, RB_SEL, RB_XFER, RB_TAG, DONE
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic [1:0]    way_q, way_d;
   logic [1:0]    rr_q, rr_d;
   logic [3:0]    mask_q, mask_d;
   logic [15:0]   dre_q, dre_d;
   logic [CW-1:0] icnt_q, icnt_d;
   logic [CW-1:0] rcnt_q, rcnt_d;

   always_ff @(posedge clk) begin
      if (rest) begin
         state_q <= IDLE;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         way_q   <= '0;
         rr_q    <= '0;
         mask_q  <= '0;
         dre_q   <= '0;
         icnt_q  <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         way_q   <= way_d;
         rr_q    <= rr_d;
         mask_q  <= mask_d;
         dre_q   <= dre_d;
         icnt_q  <= icnt_d;
         rcnt_q  <= rcnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      be_d             = be_q;
      wdata_d          = wdata_q;
      rd_d             = rd_q;
      wr_d             = wr_q;
      way_d            = way_q;
      rr_d             = rr_q;
      mask_d           = mask_q;
      dre_d            = dre_q;
      icnt_d           = icnt_q;
      rcnt_d           = rcnt_q;
      cmd_ready        = 1'b0;
      m1_address       = '0;
      m1_byteEnable    = '0;
      m1_read          = 1'b0;
      m1_write         = 1'b0;
      m1_writeData     = '0;
      data_wAddr       = '0;
      data_wWay        = way_q;
      data_wData       = '0;
      data_wEn         = 1'b0;
      data_wByteEn     = '0;
      tag_wData        = '0;
      tag_wEn          = 1'b0;
      dre_wData        = '0;
      dre_wEn          = 1'b0;
      io_readData      = '0;
      io_readDataValid = 1'b0;
      if (!rest) begin
         unique case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  addr_d  = req_address;
                  be_d    = req_byteEnable;
                  wdata_d = req_writeData;
                  rd_d    = req_read;
                  wr_d    = req_write;
                  if (cmd == CMD_IORW)
                     state_d = IO_REQ;
                  else if (cmd == CMD_RB)
                     state_d = RB_SEL;
                  else
                     state_d = DONE;
               end
            end
            IO_REQ: begin
               m1_address    = addr_q;
               m1_byteEnable = be_q;
               m1_writeData  = wdata_q;
               m1_write      = wr_q;
               m1_read       = rd_q & ~wr_q;
               if (!m1_waitRequest)
                  state_d = (rd_q & ~wr_q) ? IO_WAIT : DONE;
            end
            IO_WAIT: begin
               if (m1_readDataValid) begin
                  io_readData      = m1_readData;
                  io_readDataValid = 1'b1;
                  state_d          = DONE;
               end
            end
            RB_SEL: begin
               if (isHaveFreeBlock) begin
                  way_d = freeBlockNum;
               end else begin
                  way_d = rr_q;
                  rr_d  = rr_q + 2'd1;
               end
               mask_d  = dre_rDataAll[{way_d, 2'b00} +: 4];
               dre_d   = dre_rDataAll;
               icnt_d  = '0;
               rcnt_d  = '0;
               state_d = RB_XFER;
            end
            RB_XFER: begin
               // issue and return counters run independently
               if (icnt_q != LW) begin
                  m1_read       = 1'b1;
                  m1_byteEnable = 4'hF;
                  m1_address    = {addr_q[31:OFF+2],
                                   icnt_q[OFF-1:0], 2'b00};
                  if (!m1_waitRequest)
                     icnt_d = icnt_q + 1'b1;
               end
               if (m1_readDataValid && rcnt_q != LW) begin
                  data_wEn     = 1'b1;
                  data_wData   = m1_readData;
                  data_wByteEn = ~mask_q;
                  data_wAddr   = {addr_q[DATA_ADDR_WIDTH+1:OFF+2],
                                  rcnt_q[OFF-1:0]};
                  rcnt_d       = rcnt_q + 1'b1;
                  if (rcnt_q == LAST)
                     state_d = RB_TAG;
               end
            end
            RB_TAG: begin
               tag_wEn   = 1'b1;
               tag_wData = 32'({1'b1, addr_q[31:DATA_ADDR_WIDTH+2]});
               dre_wEn   = 1'b1;
               dre_wData = dre_q | (16'hF << {way_q, 2'b00});
               state_d   = DONE;
            end
            DONE: begin
               cmd_ready = 1'b1;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_rw_ri.sv
// Scoreboard bench for cache_rw_ri: directed IO and refill commands
// against a small bus slave, outputs checked by a negedge monitor.
`timescale 1ns/1ps
module tb_cache_rw_ri;

   logic        clk = 1'b0;
   logic        rest = 1'b1;
   logic [3:0]  cmd = '0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] req_address = '0;
   logic [3:0]  req_byteEnable = '0;
   logic        req_read = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_writeData = '0;
   logic        isHaveFreeBlock = 1'b0;
   logic [1:0]  freeBlockNum = '0;
   logic [15:0] dre_rDataAll = '0;
   logic [31:0] m1_address;
   logic [3:0]  m1_byteEnable;
   logic        m1_read;
   logic        m1_write;
   logic [31:0] m1_writeData;
   logic        m1_waitRequest = 1'b0;
   logic [31:0] m1_readData = '0;
   logic        m1_readDataValid = 1'b0;
   logic [8:0]  data_wAddr;
   logic [1:0]  data_wWay;
   logic [31:0] data_wData;
   logic        data_wEn;
   logic [3:0]  data_wByteEn;
   logic [31:0] tag_wData;
   logic        tag_wEn;
   logic [15:0] dre_wData;
   logic        dre_wEn;
   logic [31:0] io_readData;
   logic        io_readDataValid;

   cache_rw_ri dut (
      .clk(clk), .rest(rest), .cmd(cmd), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .req_address(req_address),
      .req_byteEnable(req_byteEnable), .req_read(req_read),
      .req_write(req_write), .req_writeData(req_writeData),
      .isHaveFreeBlock(isHaveFreeBlock), .freeBlockNum(freeBlockNum),
      .dre_rDataAll(dre_rDataAll), .m1_address(m1_address),
      .m1_byteEnable(m1_byteEnable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writeData(m1_writeData),
      .m1_waitRequest(m1_waitRequest), .m1_readData(m1_readData),
      .m1_readDataValid(m1_readDataValid), .data_wAddr(data_wAddr),
      .data_wWay(data_wWay), .data_wData(data_wData),
      .data_wEn(data_wEn), .data_wByteEn(data_wByteEn),
      .tag_wData(tag_wData), .tag_wEn(tag_wEn),
      .dre_wData(dre_wData), .dre_wEn(dre_wEn),
      .io_readData(io_readData), .io_readDataValid(io_readDataValid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [3:0]  b;
      logic [31:0] d;
      logic        w;
   } bus_t;
   typedef struct packed {
      logic [8:0]  a;
      logic [1:0]  way;
      logic [31:0] d;
      logic [3:0]  b;
   } dw_t;
   typedef struct packed {
      logic [31:0] a;
      int          due;
   } pend_t;

   bus_t        q_bus[$];
   dw_t         q_dw[$];
   logic [33:0] q_tag[$];
   logic [15:0] q_dre[$];
   logic [31:0] q_io[$];
   pend_t       pend[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int lat = 1;
   int wait_cnt = 0;
   bit wait_rnd = 0;
   int rdy_exp = 0;
   int rdy_seen = 0;
   int dw_seen = 0;
   int last_acc = 0;
   int last_rdy = 0;
   int last_io = 0;
   int cap = 0;

   task automatic chk(input string nm, input logic [95:0] act,
                      input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rdata(input logic [31:0] a);
      if (a == 32'h8000_0020) return 32'hDEAD_BEEF;
      return {~a[15:0], a[15:0]};
   endfunction

   always @(posedge clk) cyc++;

   // bus slave: in-order read returns after lat cycles
   initial begin
      bit          acc;
      logic [31:0] acc_a;
      pend_t       p;
      forever begin
         @(negedge clk);
         acc   = m1_read && !m1_waitRequest;
         acc_a = m1_address;
         @(posedge clk);
         #1;
         if (rest) begin
            pend.delete();
            m1_readDataValid = 1'b0;
            m1_readData      = '0;
         end else begin
            if (acc) pend.push_back('{acc_a, cyc + lat - 1});
            if (pend.size() > 0 && pend[0].due <= cyc) begin
               p = pend.pop_front();
               m1_readDataValid = 1'b1;
               m1_readData      = rdata(p.a);
            end else begin
               m1_readDataValid = 1'b0;
               m1_readData      = '0;
            end
         end
         if (wait_cnt > 0) begin
            m1_waitRequest = 1'b1;
            wait_cnt--;
         end else begin
            m1_waitRequest = wait_rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
   end

   // monitor
   initial begin
      bus_t        eb;
      dw_t         ed;
      logic [33:0] et;
      logic [15:0] er;
      logic [31:0] ei;
      forever begin
         @(negedge clk);
         if ((m1_read || m1_write) && !m1_waitRequest) begin
            last_acc = cyc + 1;
            if (q_bus.size() == 0) chk("bus_unexp", 1, 0);
            else begin
               eb = q_bus.pop_front();
               chk("bus", {m1_address, m1_byteEnable,
                   m1_write ? m1_writeData : 32'h0, m1_write}, eb);
            end
         end
         if (data_wEn) begin
            dw_seen++;
            if (q_dw.size() == 0) chk("dw_unexp", 1, 0);
            else begin
               ed = q_dw.pop_front();
               chk("dw", {data_wAddr, data_wWay, data_wData,
                   data_wByteEn}, ed);
            end
         end
         if (tag_wEn) begin
            if (q_tag.size() == 0) chk("tag_unexp", 1, 0);
            else begin
               et = q_tag.pop_front();
               chk("tag", {data_wWay, tag_wData}, et);
            end
         end
         if (dre_wEn) begin
            if (q_dre.size() == 0) chk("dre_unexp", 1, 0);
            else begin
               er = q_dre.pop_front();
               chk("dre", dre_wData, er);
            end
         end
         if (io_readDataValid) begin
            last_io = cyc + 1;
            if (q_io.size() == 0) chk("io_unexp", 1, 0);
            else begin
               ei = q_io.pop_front();
               chk("io", io_readData, ei);
            end
         end
         if (cmd_ready) begin
            rdy_seen++;
            last_rdy = cyc + 1;
            chk("rdy_unexp", rdy_seen <= rdy_exp, 1);
         end
      end
   end

   task automatic issue(input logic [3:0] c, input logic [31:0] a,
                        input logic [3:0] be, input logic rd,
                        input logic wr, input logic [31:0] wd,
                        input logic fr, input logic [1:0] fn,
                        input logic [15:0] dre);
      cmd             = c;
      req_address     = a;
      req_byteEnable  = be;
      req_read        = rd;
      req_write       = wr;
      req_writeData   = wd;
      isHaveFreeBlock = fr;
      freeBlockNum    = fn;
      dre_rDataAll    = dre;
      cmd_valid       = 1'b1;
      cap             = cyc + 1;
      @(posedge clk);
      #2;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rdy();
      int i;
      for (i = 0; i < 400; i++) begin
         if (rdy_seen == rdy_exp) break;
         @(posedge clk);
         #2;
      end
      if (i == 400) chk("rdy_timeout", 1, 0);
   endtask

   task automatic exp_refill(input logic [31:0] a, input logic [1:0] way,
                             input logic [15:0] dre, input int nwr);
      logic [31:0] base;
      logic [15:0] sh;
      logic [3:0]  be;
      base = {a[31:6], 6'b0};
      sh   = dre >> (way * 4);
      be   = ~sh[3:0];
      for (int k = 0; k < 16; k++)
         q_bus.push_back('{base + 32'(4 * k), 4'hF, 32'h0, 1'b0});
      for (int k = 0; k < nwr; k++)
         q_dw.push_back('{9'((base >> 2) + 32'(k)), way,
                          rdata(base + 32'(4 * k)), be});
      if (nwr == 16) begin
         q_tag.push_back({way, 32'h0020_0000 | (a >> 11)});
         q_dre.push_back(dre | (16'hF << (way * 4)));
      end
   endtask

   task automatic refill(input logic [31:0] a, input logic fr,
                         input logic [1:0] fn, input logic [1:0] way,
                         input logic [15:0] dre);
      exp_refill(a, way, dre, 16);
      rdy_exp++;
      issue(4'd2, a, 4'h0, 1'b1, 1'b0, 32'h0, fr, fn, dre);
      wait_rdy();
   endtask

   initial begin
      int st;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctl", {cmd_ready, m1_read, m1_write, data_wEn, tag_wEn,
          dre_wEn, io_readDataValid}, 0);
      chk("rst_data", {m1_address, io_readData}, 0);
      @(posedge clk);
      #2;
      rest = 1'b0;
      @(negedge clk);
      chk("idle_ctl", {cmd_ready, m1_read, m1_write}, 0);

      // IO write with three wait cycles
      @(posedge clk);
      #2;
      q_bus.push_back('{32'h8000_0010, 4'b0011, 32'h1234_5678, 1'b1});
      rdy_exp++;
      wait_cnt = 3;
      issue(4'd1, 32'h8000_0010, 4'b0011, 1'b0, 1'b1,
            32'h1234_5678, 1'b0, 2'd0, 16'h0);
      wait_rdy();
      chk("iow_acc_lat", last_acc - cap, 4);
      chk("iow_rdy_lat", last_rdy - last_acc, 1);

      // IO read, data back two cycles after acceptance
      lat = 2;
      q_bus.push_back('{32'h8000_0020, 4'hF, 32'h0, 1'b0});
      q_io.push_back(32'hDEAD_BEEF);
      rdy_exp++;
      issue(4'd1, 32'h8000_0020, 4'hF, 1'b1, 1'b0, 32'h0,
            1'b0, 2'd0, 16'h0);
      wait_rdy();
      chk("ior_io_lat", last_io - last_acc, 2);
      chk("ior_rdy_lat", last_rdy - last_io, 1);

      // unknown command completes straight away
      rdy_exp++;
      issue(4'd7, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 16'h0);
      wait_rdy();
      chk("nop_rdy_lat", last_rdy - cap, 1);

      // refills
      lat = 1;
      refill(32'h0000_1234, 1'b1, 2'd2, 2'd2, 16'h0000);
      wait_rnd = 1;
      lat = 2;
      refill(32'h0000_2040, 1'b1, 2'd1, 2'd1, 16'h0050);
      wait_rnd = 0;
      lat = 1;
      refill(32'h0000_4000, 1'b0, 2'd3, 2'd0, 16'h8421);
      refill(32'h0000_4440, 1'b0, 2'd3, 2'd1, 16'h8421);
      refill(32'h0000_48C0, 1'b0, 2'd3, 2'd2, 16'h8421);
      refill(32'h0000_5100, 1'b0, 2'd3, 2'd3, 16'h8421);
      refill(32'h0000_5FC0, 1'b0, 2'd3, 2'd0, 16'h8421);

      // reset after seven returns
      exp_refill(32'h0000_6000, 2'd3, 16'h0000, 7);
      st = dw_seen;
      issue(4'd2, 32'h0000_6000, 4'h0, 1'b1, 1'b0, 32'h0,
            1'b1, 2'd3, 16'h0000);
      for (int i = 0; i < 200; i++) begin
         if (dw_seen - st >= 7) break;
         @(posedge clk);
         #2;
      end
      rest = 1'b1;
      @(negedge clk);
      chk("midrst_ctl", {cmd_ready, m1_read, data_wEn, tag_wEn,
          dre_wEn}, 0);
      @(posedge clk);
      #2;
      rest = 1'b0;
      q_bus.delete();
      @(negedge clk);
      chk("midrst_idle", {cmd_ready, m1_read, m1_write}, 0);
      repeat (5) @(posedge clk);
      #2;
      chk("midrst_writes", dw_seen - st, 7);

      // round-robin restarts at way 0
      refill(32'h0000_7000, 1'b0, 2'd3, 2'd0, 16'h8421);

      repeat (3) @(posedge clk);
      chk("q_bus_left", q_bus.size(), 0);
      chk("q_dw_left", q_dw.size(), 0);
      chk("q_tag_left", q_tag.size(), 0);
      chk("q_dre_left", q_dre.size(), 0);
      chk("q_io_left", q_io.size(), 0);
      chk("rdy_count", rdy_seen, rdy_exp);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
